// File: rtl/led_pkg.sv
// Shared definitions for the multiplexed seven-segment scanner: segment bit
// positions, the hex-to-segment table and the output polarity helper.
package led_pkg;

  // Bit positions inside a 7-bit abcdefg segment word (a is the MSB).
  localparam int SEG_A = 6;
  localparam int SEG_B = 5;
  localparam int SEG_C = 4;
  localparam int SEG_D = 3;
  localparam int SEG_E = 2;
  localparam int SEG_F = 1;
  localparam int SEG_G = 0;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0:    seg = 7'b1111110;
      4'h1:    seg = 7'b0110000;
      4'h2:    seg = 7'b1101101;
      4'h3:    seg = 7'b1111001;
      4'h4:    seg = 7'b0110011;
      4'h5:    seg = 7'b1011011;
      4'h6:    seg = 7'b1011111;
      4'h7:    seg = 7'b1110000;
      4'h8:    seg = 7'b1111111;
      4'h9:    seg = 7'b1111011;
      4'hA:    seg = 7'b1110111;
      4'hB:    seg = 7'b0011111;
      4'hC:    seg = 7'b1001110;
      4'hD:    seg = 7'b0111101;
      4'hE:    seg = 7'b1001111;
      default: seg = 7'b1000111;
    endcase
    return seg;
  endfunction

  // Convert an active-high segment word to the pin level (common anode inverts).
  function automatic logic [6:0] seg_pol(input logic [6:0] seg, input bit act_low);
    return act_low ? ~seg : seg;
  endfunction

endpackage

// File: rtl/led_scan_if.sv
// Pin-side bundle of the display scanner: per-digit data/load inputs and the
// shared segment bus, one-hot digit enables and frame pulse.
interface led_scan_if #(
  parameter int DIGITS = 4
);
  // i_load is a one-cycle strobe with no backpressure: the scanner accepts
  // every strobe, and a later strobe before the frame boundary replaces the earlier one.
  logic [4*DIGITS-1:0] i_value;
  logic [DIGITS-1:0]   i_dp;
  logic [DIGITS-1:0]   i_blank;
  logic [3:0]          i_bright;
  logic                i_load;

  logic                o_a, o_b, o_c, o_d, o_e, o_f, o_g, o_dp;
  logic [DIGITS-1:0]   o_digit;
  logic                o_frame;

  modport master (
    output i_value, i_dp, i_blank, i_bright, i_load,
    input  o_a, o_b, o_c, o_d, o_e, o_f, o_g, o_dp, o_digit, o_frame
  );

  modport slave (
    input  i_value, i_dp, i_blank, i_bright, i_load,
    output o_a, o_b, o_c, o_d, o_e, o_f, o_g, o_dp, o_digit, o_frame
  );
endinterface

// File: rtl/led_hex_decoder.sv
// Combinational nibble to abcdefg segment decoder (active-high segments).
module led_hex_decoder
  import led_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg
);
  assign seg = hex_to_seg(nib);
endmodule

// File: rtl/led_scan.sv
// N-digit multiplexed seven-segment driver with double-buffered frame data,
// per-slot dead time and 16-level PWM dimming. All outputs are registered.
module led_scan
  import led_pkg::*;
#(
  parameter int DIGITS      = 4,
  parameter int SCAN_DIV    = 1024,
  parameter int DEAD        = 16,
  parameter int SEG_ACT_LOW = 0,
  parameter int DIG_ACT_LOW = 0
) (
  input logic     clk,
  input logic     rst,
  led_scan_if.slave bus
);
  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int DW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [SW-1:0] SLOT_LAST = SW'(SCAN_DIV - 1);
  localparam logic [SW-1:0] DEAD_CNT  = SW'(DEAD);
  localparam logic [DW-1:0] DIG_LAST  = DW'(DIGITS - 1);
  localparam bit SEG_INV = (SEG_ACT_LOW != 0);
  localparam bit DIG_INV = (DIG_ACT_LOW != 0);

  typedef struct packed {
    logic [4*DIGITS-1:0] value;
    logic [DIGITS-1:0]   dp;
    logic [DIGITS-1:0]   blank;
    logic [3:0]          bright;
  } disp_t;

  logic [SW-1:0]     slot_cnt;
  logic [DW-1:0]     dig;
  logic [3:0]        pwm_cnt;
  logic              pend_valid;
  disp_t             pending, active;

  logic              slot_wrap, frame_bnd, lit;
  logic [3:0]        nib;
  logic [6:0]        seg_dec;
  logic [DIGITS-1:0] dig_onehot;

  logic [6:0]        seg_q;
  logic              dp_q;
  logic [DIGITS-1:0] digit_q;
  logic              frame_q;

  always_comb begin
    slot_wrap  = (slot_cnt == SLOT_LAST);
    frame_bnd  = slot_wrap && (dig == DIG_LAST);
    nib        = active.value[{dig, 2'b00} +: 4];
    lit        = (slot_cnt >= DEAD_CNT) && (pwm_cnt < active.bright) && !active.blank[dig];
    dig_onehot = DIGITS'(1) << dig;
  end

  led_hex_decoder u_dec (
    .nib (nib),
    .seg (seg_dec)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      slot_cnt       <= '0;
      dig            <= '0;
      pwm_cnt        <= '0;
      pend_valid     <= 1'b0;
      pending        <= '0;
      active.value   <= '0;
      active.dp      <= '0;
      active.blank   <= '1;
      active.bright  <= 4'd0;
      seg_q          <= seg_pol(7'h00, SEG_INV);
      dp_q           <= SEG_INV;
      digit_q        <= {DIGITS{DIG_INV}};
      frame_q        <= 1'b0;
    end else begin
      pwm_cnt  <= pwm_cnt + 4'd1;
      slot_cnt <= slot_wrap ? '0 : slot_cnt + SW'(1);
      if (slot_wrap) begin
        dig <= (dig == DIG_LAST) ? '0 : dig + DW'(1);
      end

      // Swap only between frames so a frame never mixes old and new data;
      // a load landing on the boundary itself waits for the following frame.
      if (frame_bnd && pend_valid) begin
        active <= pending;
      end
      if (bus.i_load) begin
        pending    <= '{value: bus.i_value, dp: bus.i_dp, blank: bus.i_blank,
                        bright: bus.i_bright};
        pend_valid <= 1'b1;
      end else if (frame_bnd) begin
        pend_valid <= 1'b0;
      end

      seg_q   <= seg_pol(lit ? seg_dec : 7'h00, SEG_INV);
      dp_q    <= (lit & active.dp[dig]) ^ SEG_INV;
      digit_q <= (lit ? dig_onehot : '0) ^ {DIGITS{DIG_INV}};
      frame_q <= (slot_cnt == '0) && (dig == '0);
    end
  end

  assign bus.o_a     = seg_q[SEG_A];
  assign bus.o_b     = seg_q[SEG_B];
  assign bus.o_c     = seg_q[SEG_C];
  assign bus.o_d     = seg_q[SEG_D];
  assign bus.o_e     = seg_q[SEG_E];
  assign bus.o_f     = seg_q[SEG_F];
  assign bus.o_g     = seg_q[SEG_G];
  assign bus.o_dp    = dp_q;
  assign bus.o_digit = digit_q;
  assign bus.o_frame = frame_q;

endmodule
